// File: rtl/time_display_mux.sv
// Six-digit multiplexed 7-segment driver for the HH.MM.SS clock display.
// Snapshots hr/min/sec once per frame and converts them to BCD with a subtract-by-10 engine.
module time_display_mux #(
  parameter int SCAN_DIV     = 50_000,
  parameter bit COMMON_ANODE = 1'b1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [4:0] hr,
  input  logic [5:0] min,
  input  logic [5:0] sec,
  input  logic       blank,
  output logic [6:0] seg,
  output logic       dp,
  output logic [5:0] an
);

  localparam int CW = $clog2(SCAN_DIV);

  localparam logic [2:0] IDLE   = 3'd0;
  localparam logic [2:0] CONV_H = 3'd1;
  localparam logic [2:0] CONV_M = 3'd2;
  localparam logic [2:0] CONV_S = 3'd3;
  localparam logic [2:0] COMMIT = 3'd4;

  localparam logic [5:0] AN_OFF  = {6{COMMON_ANODE}};
  localparam logic [6:0] SEG_OFF = {7{COMMON_ANODE}};
  localparam logic       DP_OFF  = COMMON_ANODE;
  localparam logic [6:0] DASH    = 7'h40;

  logic [CW-1:0] pre;
  logic          tick;
  logic [2:0]    d;
  logic [2:0]    d_next;
  logic          frame_start;

  logic [4:0] sh_hr;
  logic [5:0] sh_min;
  logic [5:0] sh_sec;
  logic [2:0] state;
  logic [5:0] rem;
  logic [3:0] tens;
  logic       done;

  logic [3:0] t_hr_t, t_hr_u, t_min_t, t_min_u, t_sec_t, t_sec_u;
  logic [3:0] disp_hr_t, disp_hr_u, disp_min_t, disp_min_u, disp_sec_t, disp_sec_u;
  logic       bad_h, bad_m, bad_s, sec_even, valid;

  logic [3:0] digit;
  logic       digit_bad;
  logic [6:0] digit_code;
  logic       dp_code;

  logic [6:0] slot_seg, slot_seg_n;
  logic       slot_dp, slot_dp_n;
  logic       slot_on, slot_on_n;
  logic       lit;

  function automatic logic [6:0] seg7(input logic [3:0] v);
    case (v)
      4'd0:    seg7 = 7'h3F;
      4'd1:    seg7 = 7'h06;
      4'd2:    seg7 = 7'h5B;
      4'd3:    seg7 = 7'h4F;
      4'd4:    seg7 = 7'h66;
      4'd5:    seg7 = 7'h6D;
      4'd6:    seg7 = 7'h7D;
      4'd7:    seg7 = 7'h07;
      4'd8:    seg7 = 7'h7F;
      4'd9:    seg7 = 7'h6F;
      default: seg7 = 7'h00;
    endcase
  endfunction

  assign tick        = (pre == CW'(SCAN_DIV - 1));
  assign frame_start = tick && (d == 3'd5);
  assign done        = (rem < 6'd10);

  always_ff @(posedge clk or posedge rst) begin
    if (rst)       pre <= '0;
    else if (tick) pre <= '0;
    else           pre <= pre + 1'b1;
  end

  always_comb begin
    d_next = d;
    if (tick) d_next = (d == 3'd5) ? 3'd0 : d + 3'd1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) d <= 3'd5;
    else     d <= d_next;
  end

  // Each CONV state already holds its field in rem on entry, so a value v costs floor(v/10)+1 cycles.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sh_hr <= '0; sh_min <= '0; sh_sec <= '0;
      state <= IDLE; rem <= '0; tens <= '0;
      t_hr_t <= '0; t_hr_u <= '0; t_min_t <= '0; t_min_u <= '0; t_sec_t <= '0; t_sec_u <= '0;
      disp_hr_t <= '0; disp_hr_u <= '0; disp_min_t <= '0; disp_min_u <= '0;
      disp_sec_t <= '0; disp_sec_u <= '0;
      bad_h <= 1'b0; bad_m <= 1'b0; bad_s <= 1'b0; sec_even <= 1'b0; valid <= 1'b0;
    end else if (frame_start) begin
      sh_hr  <= hr;
      sh_min <= min;
      sh_sec <= sec;
      rem    <= {1'b0, hr};
      tens   <= '0;
      state  <= CONV_H;
    end else begin
      case (state)
        CONV_H: begin
          if (!done) begin
            rem <= rem - 6'd10; tens <= tens + 4'd1;
          end else begin
            t_hr_t <= tens; t_hr_u <= rem[3:0];
            rem <= sh_min; tens <= '0; state <= CONV_M;
          end
        end
        CONV_M: begin
          if (!done) begin
            rem <= rem - 6'd10; tens <= tens + 4'd1;
          end else begin
            t_min_t <= tens; t_min_u <= rem[3:0];
            rem <= sh_sec; tens <= '0; state <= CONV_S;
          end
        end
        CONV_S: begin
          if (!done) begin
            rem <= rem - 6'd10; tens <= tens + 4'd1;
          end else begin
            t_sec_t <= tens; t_sec_u <= rem[3:0];
            state <= COMMIT;
          end
        end
        COMMIT: begin
          disp_hr_t  <= t_hr_t;  disp_hr_u  <= t_hr_u;
          disp_min_t <= t_min_t; disp_min_u <= t_min_u;
          disp_sec_t <= t_sec_t; disp_sec_u <= t_sec_u;
          bad_h    <= (sh_hr > 5'd23);
          bad_m    <= (sh_min > 6'd59);
          bad_s    <= (sh_sec > 6'd59);
          sec_even <= ~sh_sec[0];
          valid    <= 1'b1;
          state    <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  always_comb begin
    digit     = 4'd0;
    digit_bad = 1'b0;
    case (d_next)
      3'd0:    begin digit = disp_sec_u; digit_bad = bad_s; end
      3'd1:    begin digit = disp_sec_t; digit_bad = bad_s; end
      3'd2:    begin digit = disp_min_u; digit_bad = bad_m; end
      3'd3:    begin digit = disp_min_t; digit_bad = bad_m; end
      3'd4:    begin digit = disp_hr_u;  digit_bad = bad_h; end
      default: begin digit = disp_hr_t;  digit_bad = bad_h; end
    endcase
    digit_code = digit_bad ? DASH : seg7(digit);
    dp_code    = ((d_next == 3'd2) || (d_next == 3'd4)) && sec_even && !bad_s;
  end

  // Slot contents are frozen at the tick so a mid-slot COMMIT never changes the lit digit.
  always_comb begin
    slot_seg_n = slot_seg;
    slot_dp_n  = slot_dp;
    slot_on_n  = slot_on;
    if (tick) begin
      slot_seg_n = digit_code;
      slot_dp_n  = dp_code;
      slot_on_n  = valid;
    end
    lit = slot_on_n && !blank;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      slot_seg <= '0;
      slot_dp  <= 1'b0;
      slot_on  <= 1'b0;
      an       <= AN_OFF;
      seg      <= SEG_OFF;
      dp       <= DP_OFF;
    end else begin
      slot_seg <= slot_seg_n;
      slot_dp  <= slot_dp_n;
      slot_on  <= slot_on_n;
      an       <= lit ? ((6'b000001 << d_next) ^ AN_OFF) : AN_OFF;
      seg      <= lit ? (slot_seg_n ^ SEG_OFF) : SEG_OFF;
      dp       <= lit ? (slot_dp_n ^ DP_OFF) : DP_OFF;
    end
  end

endmodule

// File: tb/tb_time_display_mux.sv
// Directed bench for time_display_mux: active-high and common-anode copies share all inputs,
// expected slot contents are queued as stimulus is applied and popped at mid-slot sample points.
module tb_time_display_mux;

  localparam int SD = 32;

  typedef struct packed {
    logic [15:0] tag;
    logic [5:0]  an;
    logic [6:0]  seg;
    logic        dp;
  } exp_t;

  logic       clk, rst, blank;
  logic [4:0] hr;
  logic [5:0] min, sec;
  logic [6:0] seg_a, seg_b;
  logic       dp_a, dp_b;
  logic [5:0] an_a, an_b;

  int   cyc;
  int   compared;
  int   mismatched;
  exp_t sb[$];

  time_display_mux #(.SCAN_DIV(SD), .COMMON_ANODE(1'b0)) dut_a (
    .clk(clk), .rst(rst), .hr(hr), .min(min), .sec(sec), .blank(blank),
    .seg(seg_a), .dp(dp_a), .an(an_a));

  time_display_mux #(.SCAN_DIV(SD), .COMMON_ANODE(1'b1)) dut_b (
    .clk(clk), .rst(rst), .hr(hr), .min(min), .sec(sec), .blank(blank),
    .seg(seg_b), .dp(dp_b), .an(an_b));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk or posedge rst) begin
    if (rst) cyc <= 0;
    else     cyc <= cyc + 1;
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not finish within time limit");
    $fatal(1, "[TB] watchdog expired");
  end

  function automatic logic [6:0] segOf(input int v);
    case (v)
      0: segOf = 7'h3F; 1: segOf = 7'h06; 2: segOf = 7'h5B; 3: segOf = 7'h4F;
      4: segOf = 7'h66; 5: segOf = 7'h6D; 6: segOf = 7'h7D; 7: segOf = 7'h07;
      8: segOf = 7'h7F; 9: segOf = 7'h6F; default: segOf = 7'h00;
    endcase
  endfunction

  function automatic exp_t expDigit(input int h, input int m, input int s, input int dd, input int tag);
    exp_t e;
    int   v;
    bit   bad;
    case (dd)
      0:       begin v = s % 10; bad = (s > 59); end
      1:       begin v = s / 10; bad = (s > 59); end
      2:       begin v = m % 10; bad = (m > 59); end
      3:       begin v = m / 10; bad = (m > 59); end
      4:       begin v = h % 10; bad = (h > 23); end
      default: begin v = h / 10; bad = (h > 23); end
    endcase
    e.tag = 16'(tag);
    e.an  = 6'(1 << dd);
    e.seg = bad ? 7'h40 : segOf(v);
    e.dp  = ((dd == 2) || (dd == 4)) && (s % 2 == 0) && (s <= 59);
    return e;
  endfunction

  function automatic exp_t expOff(input int tag);
    exp_t e;
    e     = '0;
    e.tag = 16'(tag);
    return e;
  endfunction

  task automatic cmp(input string nm, input int tag, input logic [7:0] obs, input logic [7:0] want);
    compared++;
    assert (obs === want) else begin
      mismatched++;
      $error("[TB] FAIL %s step %0d: observed %h expected %h", nm, tag, obs, want);
    end
  endtask

  task automatic applyStimulus(input int h, input int m, input int s);
    hr  = 5'(h);
    min = 6'(m);
    sec = 6'(s);
  endtask

  task automatic waitTo(input int target);
    if (target < cyc) begin
      compared++;
      mismatched++;
      $display("[TB] FAIL schedule: cycle %0d already past target %0d", cyc, target);
    end
    while (cyc < target) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic checkOutput();
    exp_t e;
    if (sb.size() == 0) begin
      compared++;
      mismatched++;
      $display("[TB] FAIL scoreboard: empty at cycle %0d", cyc);
    end else begin
      e = sb.pop_front();
      cmp("an_a",  int'(e.tag), {2'b0, an_a},  {2'b0, e.an});
      cmp("seg_a", int'(e.tag), {1'b0, seg_a}, {1'b0, e.seg});
      cmp("dp_a",  int'(e.tag), {7'b0, dp_a},  {7'b0, e.dp});
      cmp("an_b",  int'(e.tag), {2'b0, an_b},  {2'b0, ~e.an});
      cmp("seg_b", int'(e.tag), {1'b0, seg_b}, {1'b0, ~e.seg});
      cmp("dp_b",  int'(e.tag), {7'b0, dp_b},  {7'b0, ~e.dp});
    end
  endtask

  // Slot j starts at edge SD*j and shows digit (j-1)%6; digit 0 still carries the previous snapshot.
  task automatic slotCheck(input int j, input int h, input int m, input int s,
                           input int ph, input int pm, input int ps);
    int dd;
    dd = (j - 1) % 6;
    if (dd == 0) sb.push_back(expDigit(ph, pm, ps, 0, j));
    else         sb.push_back(expDigit(h, m, s, dd, j));
    waitTo(SD * j + SD / 2);
    checkOutput();
  endtask

  initial begin
    compared   = 0;
    mismatched = 0;
    rst        = 1'b1;
    blank      = 1'b0;
    applyStimulus(12, 34, 56);
    repeat (2) @(negedge clk);

    sb.push_back(expOff(0));
    checkOutput();
    rst = 1'b0;

    sb.push_back(expOff(1));
    waitTo(SD / 2);
    checkOutput();
    sb.push_back(expOff(2));
    waitTo(SD + SD / 2);
    checkOutput();

    for (int j = 2; j <= 12; j++) slotCheck(j, 12, 34, 56, 12, 34, 56);

    applyStimulus(23, 59, 59);
    waitTo(SD * 13 + 3);
    applyStimulus(0, 0, 0);
    slotCheck(13, 23, 59, 59, 12, 34, 56);
    for (int j = 14; j <= 18; j++) slotCheck(j, 23, 59, 59, 12, 34, 56);
    slotCheck(19, 0, 0, 0, 23, 59, 59);
    for (int j = 20; j <= 24; j++) slotCheck(j, 0, 0, 0, 23, 59, 59);

    applyStimulus(25, 7, 60);
    for (int j = 25; j <= 30; j++) slotCheck(j, 25, 7, 60, 0, 0, 0);
    slotCheck(31, 25, 7, 60, 25, 7, 60);
    slotCheck(32, 25, 7, 60, 25, 7, 60);

    blank = 1'b1;
    sb.push_back(expOff(100));
    waitTo(SD * 32 + SD / 2 + 1);
    checkOutput();
    waitTo(SD * 32 + SD / 2 + 10);
    blank = 1'b0;
    sb.push_back(expDigit(25, 7, 60, 1, 101));
    waitTo(SD * 32 + SD / 2 + 11);
    checkOutput();

    for (int j = 33; j <= 36; j++) slotCheck(j, 25, 7, 60, 25, 7, 60);
    applyStimulus(12, 34, 56);
    waitTo(SD * 37 + 3);
    rst = 1'b1;
    #1;
    sb.push_back(expOff(200));
    checkOutput();
    applyStimulus(1, 2, 3);
    @(negedge clk);
    rst = 1'b0;

    sb.push_back(expOff(201));
    waitTo(SD / 2);
    checkOutput();
    sb.push_back(expOff(202));
    waitTo(SD + SD / 2);
    checkOutput();
    for (int j = 2; j <= 7; j++) slotCheck(j, 1, 2, 3, 1, 2, 3);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
